// File: rtl/lcd_driver.sv
// HD44780-style 8-bit parallel LCD driver: power-up init, timed bus writes,
// and 2x16 cursor tracking with automatic line-change commands.
module lcd_driver #(
    parameter int EN_PULSE_CYCLES   = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int POWERUP_CYCLES    = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_enable,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic [7:0] data,
    output logic       ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic [4:0] cursor_pos
);
    localparam int MAX_A   = (EN_PULSE_CYCLES > CMD_WAIT_CYCLES) ? EN_PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_B   = (CLEAR_WAIT_CYCLES > POWERUP_CYCLES) ? CLEAR_WAIT_CYCLES : POWERUP_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(EN_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST     = CW'(CMD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST   = CW'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] POWERUP_LAST = CW'(POWERUP_CYCLES - 1);

    typedef enum logic [2:0] {POWERUP, IDLE, SETUP, PULSE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q, clr_q;
    logic          in_init;
    logic [1:0]    init_idx;
    logic          wrap_pending;
    logic [7:0]    wrap_byte;
    logic          long_wait;

    logic we_rise, clr_rise;
    assign we_rise  = write_enable & ~we_q;
    assign clr_rise = clear & ~clr_q;

    assign lcd_rw = 1'b0;
    assign lcd_on = 1'b1;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Clear-display and return-home need the long settle time.
    function automatic logic is_long(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= POWERUP;
            cnt          <= '0;
            we_q         <= 1'b0;
            clr_q        <= 1'b0;
            in_init      <= 1'b0;
            init_idx     <= 2'd0;
            wrap_pending <= 1'b0;
            wrap_byte    <= 8'h00;
            long_wait    <= 1'b0;
            ready        <= 1'b0;
            lcd_data     <= 8'h00;
            lcd_rs       <= 1'b0;
            lcd_en       <= 1'b0;
            cursor_pos   <= 5'd0;
        end else begin
            we_q  <= write_enable;
            clr_q <= clear;
            case (state)
                POWERUP: begin
                    if (cnt == POWERUP_LAST) begin
                        cnt       <= '0;
                        in_init   <= 1'b1;
                        init_idx  <= 2'd0;
                        lcd_rs    <= 1'b0;
                        lcd_data  <= init_cmd(2'd0);
                        long_wait <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_rise) begin
                        lcd_rs     <= 1'b0;
                        lcd_data   <= 8'h01;
                        long_wait  <= 1'b1;
                        cursor_pos <= 5'd0;
                        ready      <= 1'b0;
                        state      <= SETUP;
                    end else if (we_rise) begin
                        ready <= 1'b0;
                        state <= SETUP;
                        if (mode == 2'b10) begin
                            lcd_rs    <= 1'b0;
                            lcd_data  <= data;
                            long_wait <= is_long(1'b0, data);
                            if (is_long(1'b0, data))
                                cursor_pos <= 5'd0;
                        end else begin
                            lcd_rs    <= 1'b1;
                            lcd_data  <= (mode == 2'b01) ? hex_ascii(data[3:0]) : data;
                            long_wait <= 1'b0;
                            // Last column: queue the DDRAM jump to the other line.
                            if (cursor_pos[3:0] == 4'hF) begin
                                wrap_pending <= 1'b1;
                                wrap_byte    <= cursor_pos[4] ? 8'h80 : 8'hC0;
                                cursor_pos   <= {~cursor_pos[4], 4'h0};
                            end else begin
                                cursor_pos <= cursor_pos + 5'd1;
                            end
                        end
                    end
                end
                SETUP: begin
                    cnt    <= '0;
                    lcd_en <= 1'b1;
                    state  <= PULSE;
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == (long_wait ? CLEAR_LAST : CMD_LAST)) begin
                        cnt <= '0;
                        if (in_init && init_idx != 2'd3) begin
                            init_idx  <= init_idx + 2'd1;
                            lcd_rs    <= 1'b0;
                            lcd_data  <= init_cmd(init_idx + 2'd1);
                            long_wait <= is_long(1'b0, init_cmd(init_idx + 2'd1));
                            state     <= SETUP;
                        end else if (in_init) begin
                            in_init    <= 1'b0;
                            cursor_pos <= 5'd0;
                            ready      <= 1'b1;
                            state      <= IDLE;
                        end else if (wrap_pending) begin
                            wrap_pending <= 1'b0;
                            lcd_rs       <= 1'b0;
                            lcd_data     <= wrap_byte;
                            long_wait    <= 1'b0;
                            state        <= SETUP;
                        end else begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= POWERUP;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: per-cycle schedule model of the LCD bus
// plus directed literal checks and a randomized request phase.
module tb_lcd_driver;
    localparam int EN  = 2;
    localparam int CWT = 4;
    localparam int CLW = 8;
    localparam int PU  = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_enable, clear;
    logic [1:0] mode;
    logic [7:0] data;
    logic       ready;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [4:0] cursor_pos;

    lcd_driver #(
        .EN_PULSE_CYCLES(EN), .CMD_WAIT_CYCLES(CWT),
        .CLEAR_WAIT_CYCLES(CLW), .POWERUP_CYCLES(PU)
    ) dut (
        .clock(clock), .reset(reset), .write_enable(write_enable), .clear(clear),
        .mode(mode), .data(data), .ready(ready), .lcd_data(lcd_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
        .cursor_pos(cursor_pos)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus state for one clock cycle.
    typedef struct packed {
        logic       en;
        logic       chk;
        logic       rs;
        logic [7:0] data;
        logic       rdy;
    } exp_t;

    exp_t sched[$];
    exp_t cur;
    bit   model_live = 0;
    int   m_row, m_col;
    logic prev_we, prev_clr;
    logic [8:0] txlog[$];

    function automatic exp_t mk(input logic en, input logic chk, input logic rs,
                                input logic [7:0] d, input logic rdy);
        exp_t e;
        e.en = en; e.chk = chk; e.rs = rs; e.data = d; e.rdy = rdy;
        return e;
    endfunction

    function automatic void push_txn(input logic rs, input logic [7:0] b);
        int w;
        w = (!rs && (b == 8'h01 || b == 8'h02)) ? CLW : CWT;
        sched.push_back(mk(1'b0, 1'b1, rs, b, 1'b0));
        for (int i = 0; i < EN; i++) sched.push_back(mk(1'b1, 1'b1, rs, b, 1'b0));
        for (int i = 0; i < w; i++)  sched.push_back(mk(1'b0, 1'b1, rs, b, 1'b0));
    endfunction

    // Reference model: advances one cycle per rising edge.
    always @(posedge clock) begin
        logic acc_we, acc_clr;
        logic [7:0] ch;
        logic [3:0] n;
        if (reset) begin
            sched.delete();
            for (int i = 0; i < PU; i++) sched.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0));
            push_txn(1'b0, 8'h38);
            push_txn(1'b0, 8'h0C);
            push_txn(1'b0, 8'h06);
            push_txn(1'b0, 8'h01);
            m_row = 0; m_col = 0;
            prev_we = 1'b0; prev_clr = 1'b0;
            cur = sched.pop_front();
            model_live = 1;
        end else if (model_live) begin
            acc_clr = cur.rdy && clear && !prev_clr;
            acc_we  = cur.rdy && write_enable && !prev_we;
            prev_we = write_enable;
            prev_clr = clear;
            if (acc_clr) begin
                push_txn(1'b0, 8'h01);
                m_row = 0; m_col = 0;
            end else if (acc_we) begin
                if (mode == 2'b10) begin
                    push_txn(1'b0, data);
                    if (data == 8'h01 || data == 8'h02) begin m_row = 0; m_col = 0; end
                end else begin
                    n = data[3:0];
                    if (mode == 2'b01) ch = (n < 10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
                    else ch = data;
                    push_txn(1'b1, ch);
                    if (m_col == 15) begin
                        push_txn(1'b0, (m_row == 1) ? 8'h80 : 8'hC0);
                        m_row = 1 - m_row;
                        m_col = 0;
                    end else begin
                        m_col++;
                    end
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    logic prev_en_mon = 1'b0;
    always @(negedge clock) begin
        if (model_live) begin
            check("lcd_en", lcd_en, cur.en);
            check("ready", ready, cur.rdy);
            check("lcd_rw", lcd_rw, 0);
            check("lcd_on", lcd_on, 1);
            if (cur.chk) begin
                check("lcd_rs", lcd_rs, cur.rs);
                check("lcd_data", lcd_data, cur.data);
            end
            if (cur.rdy) check("cursor_pos", cursor_pos, m_row * 16 + m_col);
        end
        if (lcd_en && !prev_en_mon) txlog.push_back({lcd_rs, lcd_data});
        prev_en_mon = lcd_en;
    end

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready && n < 2000);
    endtask

    task automatic req(input logic w, input logic c, input logic [1:0] m,
                       input logic [7:0] d, output int busy);
        txlog.delete();
        write_enable = w; clear = c; mode = m; data = d;
        @(negedge clock);
        write_enable = 1'b0; clear = 1'b0;
        busy = 0;
        while (!ready && busy < 1000) begin
            busy++;
            @(negedge clock);
        end
    endtask

    task automatic check_init_log();
        check("init_count", txlog.size(), 4);
        if (txlog.size() == 4) begin
            check("init_0", txlog[0], 9'h038);
            check("init_1", txlog[1], 9'h00C);
            check("init_2", txlog[2], 9'h006);
            check("init_3", txlog[3], 9'h001);
        end
    endtask

    initial begin
        int n, busy;
        reset = 1'b1; write_enable = 1'b0; clear = 1'b0; mode = 2'b00; data = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready, 0);
        check("rst_en", lcd_en, 0);
        check("rst_data", lcd_data, 0);
        check("rst_cursor", cursor_pos, 0);
        txlog.delete();
        reset = 1'b0;
        wait_ready(n);
        check("powerup_ready_cycles", n, 42);
        check_init_log();
        check("init_cursor", cursor_pos, 0);

        req(1'b1, 1'b0, 2'b00, 8'h41, busy);
        check("char_busy", busy, 7);
        check("char_log", (txlog.size() == 1) ? txlog[0] : 9'h1FF, 9'h141);
        check("char_cursor", cursor_pos, 5'h01);

        req(1'b1, 1'b0, 2'b01, 8'hFB, busy);
        check("hex_B", (txlog.size() == 1) ? txlog[0] : 9'h1FF, 9'h142);
        req(1'b1, 1'b0, 2'b01, 8'h07, busy);
        check("hex_7", (txlog.size() == 1) ? txlog[0] : 9'h1FF, 9'h137);

        req(1'b1, 1'b1, 2'b00, 8'h55, busy);
        check("clear_busy", busy, 11);
        check("clear_log", (txlog.size() == 1) ? txlog[0] : 9'h1FF, 9'h001);
        check("clear_cursor", cursor_pos, 0);

        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < 16; i++) begin
                req(1'b1, 1'b0, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 8'h61 + 8'(i), busy);
                if (i < 15) check("row_busy", busy, 7);
            end
            check("wrap_busy", busy, 14);
            check("wrap_log", (txlog.size() == 2) ? txlog[1] : 9'h1FF,
                  (line == 0) ? 9'h0C0 : 9'h080);
            check("wrap_cursor", cursor_pos, (line == 0) ? 5'h10 : 5'h00);
        end

        txlog.delete();
        write_enable = 1'b1; mode = 2'b00; data = 8'h5A;
        repeat (50) @(negedge clock);
        write_enable = 1'b0;
        wait_ready(n);
        check("held_once", txlog.size(), 1);

        txlog.delete();
        write_enable = 1'b1; data = 8'h31;
        @(negedge clock);
        write_enable = 1'b0;
        repeat (2) @(negedge clock);
        write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
        wait_ready(n);
        repeat (3) @(negedge clock);
        check("busy_ignored", txlog.size(), 1);

        req(1'b1, 1'b0, 2'b10, 8'h0F, busy);
        check("raw_busy", busy, 7);
        check("raw_log", (txlog.size() == 1) ? txlog[0] : 9'h1FF, 9'h00F);
        check("raw_cursor", cursor_pos, 5'h02);
        req(1'b1, 1'b0, 2'b10, 8'h02, busy);
        check("home_busy", busy, 11);
        check("home_cursor", cursor_pos, 0);

        repeat (3000) begin
            @(negedge clock);
            write_enable = ($urandom_range(0, 3) == 0);
            clear        = ($urandom_range(0, 15) == 0);
            mode         = 2'($urandom_range(0, 3));
            data         = 8'($urandom_range(0, 255));
        end
        write_enable = 1'b0; clear = 1'b0;
        wait_ready(n);
        @(negedge clock);

        write_enable = 1'b1; mode = 2'b00; data = 8'h48;
        @(negedge clock);
        write_enable = 1'b0;
        n = 0;
        while (!lcd_en && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("reached_pulse", lcd_en, 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_en", lcd_en, 0);
        check("abort_ready", ready, 0);
        txlog.delete();
        reset = 1'b0;
        wait_ready(n);
        check("reinit_ready_cycles", n, 42);
        check_init_log();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
